// File: rtl/dslv_pkg.sv
// rtl/dslv_pkg.sv - shared types and constants for the data-SRAM responder
//
// Purpose: size encodings, the response-queue entry layout, the age counter
// width, the stall LFSR seed and a byte-lane merge helper used by the
// memory write path.
// Ports: none (package).
package dslv_pkg;

  localparam int AGE_W = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // wr=1 entries carry no data; data is the captured read word otherwise.
  typedef struct packed {
    logic             wr;
    logic [31:0]      data;
    logic [AGE_W-1:0] age;
  } resp_entry_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_slave_if.sv
// rtl/data_sram_slave_if.sv - request/response bundle of the data-SRAM-like bus
//
// Purpose: groups the request channel (req/addr_ok) and the response
// channel (data_ok/rdata) between an initiator and the memory responder.
// Signals:
//   req      initiator request valid
//   wr       1 = write, 0 = read
//   size     access size (informational, wstrb is authoritative)
//   wstrb    write byte enables
//   addr     byte address
//   wdata    write data
//   addr_ok  request accepted when req is also high
//   data_ok  one transaction completes this cycle
//   rdata    read data, valid with data_ok
// Modports: master (initiator side), slave (memory side).
interface data_sram_slave_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/dslv_resp_fifo.sv
// rtl/dslv_resp_fifo.sv - in-order response queue with per-entry age counters
//
// Purpose: holds accepted-but-unanswered transactions. Each entry ages by
// one every cycle (saturating at LATENCY); the head is ready once its age
// reaches LATENCY-1 so that its pop edge lands LATENCY edges after push.
// Ports:
//   clk            clock
//   reset          synchronous active-high reset, empties the queue
//   push_i         write push_entry_i at the tail
//   push_entry_i   entry to store (age field is expected to be zero)
//   pop_i          drop the head entry (only legal when head_ready_o)
//   count_o        number of stored entries
//   head_ready_o   head valid and old enough to be answered
//   head_wr_o      head entry is a write
//   head_data_o    head entry read data
module dslv_resp_fifo
  import dslv_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  resp_entry_t                push_entry_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       head_ready_o,
  output logic                       head_wr_o,
  output logic [31:0]                head_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [AGE_W-1:0] AGE_POP = AGE_W'(LATENCY - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);

  resp_entry_t      ent_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  resp_entry_t      head;

  assign head         = ent_q[rd_ptr_q];
  assign head_ready_o = (count_q != '0) && (head.age >= AGE_POP);
  assign head_wr_o    = head.wr;
  assign head_data_o  = head.data;
  assign count_o      = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      // Empty slots age too; harmless, they are overwritten on push.
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].age < AGE_MAX) ent_q[i].age <= ent_q[i].age + 1'b1;
      end
      // The push write comes after the ageing loop so a new entry starts at 0.
      if (push_i) begin
        ent_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/data_sram_slave.sv
// rtl/data_sram_slave.sv - data-SRAM-like responder with pipelined in-order replies
//
// Purpose: memory end of the CPU data-SRAM-like bus. Accepts one request per
// cycle while the response queue has room (or frees a slot that cycle),
// applies byte-masked writes / captures read words on acceptance, and
// answers every transaction with one data_ok after LATENCY cycles.
// Optional build macro: DSLV_RAND_STALL_EN adds a 16-bit LFSR that randomly
// withholds addr_ok; response timing is unaffected.
// Ports:
//   clk     clock
//   reset   synchronous active-high reset (memory contents are kept)
//   mem_if  data_sram_slave_if.slave request/response bundle
module data_sram_slave
  import dslv_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  data_sram_slave_if.slave    mem_if
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(OUTSTANDING);

  logic [31:0]       mem_q [DEPTH];
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       rd_word;

  logic [PTR_W:0]    fifo_count;
  logic              head_ready;
  logic              head_wr;
  logic [31:0]       head_data;
  logic              pop;
  logic              push;
  logic              stall;
  logic              addr_ok;
  resp_entry_t       push_entry;

  logic              data_ok_q;
  logic              data_ok_d;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_d;

  // Size and the out-of-range address bits do not affect the access.
  logic              unused_bits;
  assign unused_bits = ^{mem_if.size, mem_if.addr[31:MEM_AW+2], mem_if.addr[1:0]};

`ifdef DSLV_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci form, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // No response back-pressure: the head leaves as soon as it is old enough.
  assign pop = head_ready;

  // A full queue that pops this cycle still has room for the new request.
  assign addr_ok = ~reset & ~stall & ((fifo_count < CNT_FULL) | pop);
  assign push    = mem_if.req & addr_ok;

  assign word_idx = mem_if.addr[MEM_AW+1:2];
  // Combinational read of the registered array gives the pre-write value
  // should a write to the same word land on the same edge.
  assign rd_word  = mem_q[word_idx];

  always_comb begin
    push_entry      = '0;
    push_entry.wr   = mem_if.wr;
    push_entry.data = mem_if.wr ? 32'h0 : rd_word;
  end

  always_ff @(posedge clk) begin
    if (push && mem_if.wr) begin
      mem_q[word_idx] <= byte_merge(mem_q[word_idx], mem_if.wdata, mem_if.wstrb);
    end
  end

  dslv_resp_fifo #(
    .DEPTH   (OUTSTANDING),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (fifo_count),
    .head_ready_o (head_ready),
    .head_wr_o    (head_wr),
    .head_data_o  (head_data)
  );

  always_comb begin
    data_ok_d = pop;
    rdata_d   = (pop && !head_wr) ? head_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mem_if.addr_ok = addr_ok;
  assign mem_if.data_ok = data_ok_q;
  assign mem_if.rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// tb/tb_data_sram_slave.sv - self-checking bench for data_sram_slave
module tb_data_sram_slave;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_sram_slave_if bus_a ();
  data_sram_slave_if bus_b ();

  data_sram_slave #(.MEM_AW(10), .LATENCY(2), .OUTSTANDING(4)) dut_a (
    .clk (clk), .reset (reset), .mem_if (bus_a)
  );

  data_sram_slave #(.MEM_AW(4), .LATENCY(8), .OUTSTANDING(4)) dut_b (
    .clk (clk), .reset (reset), .mem_if (bus_b)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
  } vec_t;

  int errors = 0;
  int checks = 0;

  vec_t tab_a [23];
  vec_t tab_b [20];

  logic [31:0] ref_mem [16];
  logic [31:0] sb_q [$];
  logic        r_wr;
  logic [3:0]  r_idx;
  logic [3:0]  r_strb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] e_rd;
  bit          pending;
  bit          saw_stall;
  int          issued, acc, dok_cnt, guard, n_req;

  function automatic vec_t mk(input logic rst, input logic req, input logic wr,
                              input logic [3:0] strb, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic aok,
                              input logic dok, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.strb = strb; v.addr = addr;
    v.wdata = wdata; v.aok = aok; v.dok = dok; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = 2'd2; bus_a.wstrb = 4'h0;
    bus_a.addr = 32'h0; bus_a.wdata = 32'h0;
    bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = 2'd2; bus_b.wstrb = 4'h0;
    bus_b.addr = 32'h0; bus_b.wdata = 32'h0;
  endtask

  task automatic apply(input vec_t v, input bit sel, input int i);
    reset = v.rst;
    if (!sel) begin
      bus_a.req = v.req; bus_a.wr = v.wr; bus_a.wstrb = v.strb;
      bus_a.addr = v.addr; bus_a.wdata = v.wdata;
    end else begin
      bus_b.req = v.req; bus_b.wr = v.wr; bus_b.wstrb = v.strb;
      bus_b.addr = v.addr; bus_b.wdata = v.wdata;
    end
    #1;
    if (!sel) begin
      chk($sformatf("a[%0d].addr_ok", i), bus_a.addr_ok, v.aok);
      chk($sformatf("a[%0d].data_ok", i), bus_a.data_ok, v.dok);
      chk($sformatf("a[%0d].rdata", i),   bus_a.rdata,   v.rd);
    end else begin
      chk($sformatf("b[%0d].addr_ok", i), bus_b.addr_ok, v.aok);
      chk($sformatf("b[%0d].data_ok", i), bus_b.data_ok, v.dok);
      chk($sformatf("b[%0d].rdata", i),   bus_b.rdata,   v.rd);
    end
    @(posedge clk); #1;
  endtask

  // Full-word write into dut_b, waiting for both handshakes with a bound.
  task automatic b_write(input int i);
    int n;
    bus_b.req = 1'b1; bus_b.wr = 1'b1; bus_b.wstrb = 4'hF;
    bus_b.addr = 32'(i * 4); bus_b.wdata = 32'hC0DE0000 | 32'(i);
    #1;
    n = 0;
    while (bus_b.addr_ok !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b_write.addr_ok", bus_b.addr_ok, 1);
    @(posedge clk); #1;
    bus_b.req = 1'b0;
    n = 0;
    while (bus_b.data_ok !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b_write.data_ok", bus_b.data_ok, 1);
    chk("b_write.rdata", bus_b.rdata, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // dut_a (LATENCY=2): request in row r answers in row r+3.
    tab_a[0]  = mk(1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0);
    tab_a[1]  = mk(0, 1, 1, 4'hF, 32'h10,   32'hDEADBEEF, 1, 0, 32'h0);
    tab_a[2]  = mk(0, 1, 0, 4'h0, 32'h10,   32'h0,        1, 0, 32'h0);
    tab_a[3]  = mk(0, 1, 1, 4'hF, 32'h20,   32'h11223344, 1, 0, 32'h0);
    tab_a[4]  = mk(0, 1, 1, 4'h4, 32'h20,   32'hAABBCCDD, 1, 1, 32'h0);
    tab_a[5]  = mk(0, 1, 0, 4'h0, 32'h20,   32'h0,        1, 1, 32'hDEADBEEF);
    tab_a[6]  = mk(0, 1, 1, 4'hF, 32'h1004, 32'h00000055, 1, 1, 32'h0);
    tab_a[7]  = mk(0, 1, 0, 4'h0, 32'h0004, 32'h0,        1, 1, 32'h0);
    tab_a[8]  = mk(0, 1, 1, 4'h0, 32'h20,   32'hFFFFFFFF, 1, 1, 32'h11BB3344);
    tab_a[9]  = mk(0, 1, 0, 4'h0, 32'h20,   32'h0,        1, 1, 32'h0);
    tab_a[10] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 1, 32'h00000055);
    tab_a[11] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 1, 32'h0);
    tab_a[12] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 1, 32'h11BB3344);
    tab_a[13] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 32'h0);
    // Two reads in flight, reset the cycle before the first would answer.
    tab_a[14] = mk(0, 1, 0, 4'h0, 32'h10,   32'h0,        1, 0, 32'h0);
    tab_a[15] = mk(0, 1, 0, 4'h0, 32'h1004, 32'h0,        1, 0, 32'h0);
    tab_a[16] = mk(1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0);
    tab_a[17] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 32'h0);
    tab_a[18] = mk(0, 1, 0, 4'h0, 32'h20,   32'h0,        1, 0, 32'h0);
    tab_a[19] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 32'h0);
    tab_a[20] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 32'h0);
    tab_a[21] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 1, 32'h11BB3344);
    tab_a[22] = mk(0, 0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 32'h0);

    // dut_b (LATENCY=8, depth 4): six reads held until accepted.
    for (int i = 0; i < 4; i++) tab_b[i] = mk(0, 1, 0, 4'h0, 32'(i * 4), 32'h0, 1, 0, 32'h0);
    for (int i = 4; i < 8; i++) tab_b[i] = mk(0, 1, 0, 4'h0, 32'h10, 32'h0, 0, 0, 32'h0);
    tab_b[8]  = mk(0, 1, 0, 4'h0, 32'h10, 32'h0, 1, 0, 32'h0);
    tab_b[9]  = mk(0, 1, 0, 4'h0, 32'h14, 32'h0, 1, 1, 32'hC0DE0000);
    tab_b[10] = mk(0, 0, 0, 4'h0, 32'h0,  32'h0, 1, 1, 32'hC0DE0001);
    tab_b[11] = mk(0, 0, 0, 4'h0, 32'h0,  32'h0, 1, 1, 32'hC0DE0002);
    tab_b[12] = mk(0, 0, 0, 4'h0, 32'h0,  32'h0, 1, 1, 32'hC0DE0003);
    for (int i = 13; i < 17; i++) tab_b[i] = mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
    tab_b[17] = mk(0, 0, 0, 4'h0, 32'h0,  32'h0, 1, 1, 32'hC0DE0004);
    tab_b[18] = mk(0, 0, 0, 4'h0, 32'h0,  32'h0, 1, 1, 32'hC0DE0005);
    tab_b[19] = mk(0, 0, 0, 4'h0, 32'h0,  32'h0, 1, 0, 32'h0);

    idle_bus();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

`ifndef DSLV_RAND_STALL_EN
    for (int i = 0; i < 23; i++) apply(tab_a[i], 1'b0, i);
    reset = 1'b0;
    bus_a.req = 1'b0;
    for (int i = 0; i < 6; i++) b_write(i);
    for (int i = 0; i < 20; i++) apply(tab_b[i], 1'b1, i);
    bus_b.req = 1'b0;
    n_req = 200;
`else
    n_req = 1000;
`endif
    reset = 1'b0;

    // Randomised traffic on dut_a against a reference memory and an
    // in-order expected-response queue.
    pending = 0; saw_stall = 0; issued = 0; acc = 0; dok_cnt = 0; guard = 0;
    while ((issued < n_req || pending || sb_q.size() != 0) && guard < 20000) begin
      guard++;
      if (!pending && issued < n_req && $urandom_range(3) != 0) begin
        if (issued < 16) begin
          r_wr = 1'b1; r_idx = issued[3:0]; r_strb = 4'hF;
        end else begin
          r_wr = 1'($urandom_range(1));
          r_idx = 4'($urandom_range(15));
          r_strb = 4'($urandom_range(15));
        end
        r_addr = $urandom;
        r_addr[11:2] = {6'd0, r_idx};
        r_wdata = $urandom;
        pending = 1;
        issued++;
      end
      bus_a.req = pending; bus_a.wr = r_wr; bus_a.wstrb = r_strb;
      bus_a.addr = r_addr; bus_a.wdata = r_wdata;
      #1;
      if (bus_a.data_ok !== 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("rand.spurious_data_ok", bus_a.data_ok, 0);
        end else begin
          e_rd = sb_q.pop_front();
          chk($sformatf("rand.rdata#%0d", dok_cnt), bus_a.rdata, e_rd);
          dok_cnt++;
        end
      end
`ifdef DSLV_RAND_STALL_EN
      if (bus_a.addr_ok === 1'b0 && sb_q.size() < 4) saw_stall = 1;
`endif
      if (pending && bus_a.addr_ok === 1'b1) begin
        if (r_wr) begin
          sb_q.push_back(32'h0);
          for (int b = 0; b < 4; b++)
            if (r_strb[b]) ref_mem[r_idx][8*b +: 8] = r_wdata[8*b +: 8];
        end else begin
          sb_q.push_back(ref_mem[r_idx]);
        end
        pending = 0;
        acc++;
      end
      @(posedge clk); #1;
    end
    bus_a.req = 1'b0;
    chk("rand.pending", 32'(pending), 0);
    chk("rand.queue_empty", sb_q.size(), 0);
    chk("rand.accepted", acc, n_req);
    chk("rand.data_ok_count", dok_cnt, acc);
`ifdef DSLV_RAND_STALL_EN
    chk("rand.stall_seen", 32'(saw_stall), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("rand.quiet_data_ok", bus_a.data_ok, 0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
